axi4_burst_mem_slave: RTL and testbench

//  AXI4 memory-mapped slave with INCR/FIXED bursts and word-addressed RAM. Sits directly downstream of the

---
 rtl/axi4_burst_mem_slave.sv | 197 +++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: independent write/read FSMs sharing one word-addressed RAM.
// Optional macro AXI_MEM_RANGE_CHECK_EN turns out-of-window beats into SLVERR instead of wrapping.
module axi4_burst_mem_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_SIZE   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic [7:0]              S_AXI_awlen,
    input  logic [2:0]              S_AXI_awsize,
    input  logic [1:0]              S_AXI_awburst,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wlast,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic [7:0]              S_AXI_arlen,
    input  logic [2:0]              S_AXI_arsize,
    input  logic [1:0]              S_AXI_arburst,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rlast,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready
);
    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam int                    SHIFT      = $clog2(STRB_W);
    localparam int                    IDX_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] DEPTH      = ADDR_WIDTH'(MEM_SIZE);
    localparam logic [1:0]            FIXED      = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    // Transfer size is fixed at full width, so the size fields carry no information.
    logic unused_size;
    assign unused_size = ^{S_AXI_awsize, S_AXI_arsize};

    function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> SHIFT;
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(word_of(a) % DEPTH);
    endfunction

    wstate_t               w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [1:0]            w_burst;
    logic                  w_err, w_ok, w_final;
    logic                  aw_hs, w_hs, b_hs;

    rstate_t               r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_next, r_load_addr;
    logic [7:0]            r_len, r_cnt;
    logic [1:0]            r_burst;
    logic                  r_load_ok;
    logic                  ar_hs, r_hs;

    assign aw_hs   = S_AXI_awvalid && S_AXI_awready;
    assign w_hs    = S_AXI_wvalid && S_AXI_wready;
    assign b_hs    = S_AXI_bvalid && S_AXI_bready;
    assign w_final = (w_cnt == w_len);

    assign ar_hs       = S_AXI_arvalid && S_AXI_arready;
    assign r_hs        = S_AXI_rvalid && S_AXI_rready;
    assign r_addr_next = (r_burst != FIXED) ? r_addr + BEAT_BYTES : r_addr;
    assign r_load_addr = ar_hs ? S_AXI_araddr : r_addr_next;

`ifdef AXI_MEM_RANGE_CHECK_EN
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (word_of(a) < DEPTH);
    endfunction
    assign w_ok      = in_range(w_addr);
    assign r_load_ok = in_range(r_load_addr);
`else
    assign w_ok      = 1'b1;
    assign r_load_ok = 1'b1;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_awready = (w_state == W_IDLE);
        S_AXI_wready  = (w_state == W_DATA);
        S_AXI_bvalid  = (w_state == W_RESP);
        S_AXI_bresp   = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;
    end

    // Error is sticky for the burst: any wlast misplacement or rejected beat yields SLVERR.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= S_AXI_awaddr;
            w_len   <= S_AXI_awlen;
            w_burst <= S_AXI_awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            if (w_burst != FIXED) w_addr <= w_addr + BEAT_BYTES;
            w_cnt <= w_cnt + 8'd1;
            if ((S_AXI_wlast != w_final) || !w_ok) w_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_hs && w_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_wstrb[b]) mem[index_of(w_addr)][b*8 +: 8] <= S_AXI_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && S_AXI_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_arready = (r_state == R_IDLE);
        S_AXI_rvalid  = (r_state == R_DATA);
    end

    // Read data is registered from the RAM, so a same-cycle write to that word is not yet visible.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            S_AXI_rdata <= '0;
            S_AXI_rresp <= 2'b00;
            S_AXI_rlast <= 1'b0;
        end else if (ar_hs) begin
            r_addr      <= S_AXI_araddr;
            r_len       <= S_AXI_arlen;
            r_burst     <= S_AXI_arburst;
            r_cnt       <= '0;
            S_AXI_rlast <= (S_AXI_arlen == 8'd0);
            S_AXI_rdata <= r_load_ok ? mem[index_of(r_load_addr)] : '0;
            S_AXI_rresp <= r_load_ok ? 2'b00 : 2'b10;
        end else if (r_hs) begin
            if (S_AXI_rlast) begin
                S_AXI_rlast <= 1'b0;
            end else begin
                r_addr      <= r_addr_next;
                r_cnt       <= r_cnt + 8'd1;
                S_AXI_rlast <= ((r_cnt + 8'd1) == r_len);
                S_AXI_rdata <= r_load_ok ? mem[index_of(r_load_addr)] : '0;
                S_AXI_rresp <= r_load_ok ? 2'b00 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Scoreboard bench for axi4_burst_mem_slave: drivers push expected B/R responses, a monitor pops and compares.
module tb_axi4_burst_mem_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] S_AXI_awaddr = '0;
    logic [7:0]  S_AXI_awlen = '0;
    logic [2:0]  S_AXI_awsize = 3'd2;
    logic [1:0]  S_AXI_awburst = '0;
    logic        S_AXI_awvalid = 1'b0;
    logic        S_AXI_awready;
    logic [31:0] S_AXI_wdata = '0;
    logic [3:0]  S_AXI_wstrb = '0;
    logic        S_AXI_wlast = 1'b0;
    logic        S_AXI_wvalid = 1'b0;
    logic        S_AXI_wready;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready = 1'b0;
    logic [31:0] S_AXI_araddr = '0;
    logic [7:0]  S_AXI_arlen = '0;
    logic [2:0]  S_AXI_arsize = 3'd2;
    logic [1:0]  S_AXI_arburst = '0;
    logic        S_AXI_arvalid = 1'b0;
    logic        S_AXI_arready;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rlast;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready = 1'b0;

    always #5 ACLK = ~ACLK;

    axi4_burst_mem_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen), .S_AXI_awsize(S_AXI_awsize),
        .S_AXI_awburst(S_AXI_awburst), .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
        .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
        .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arsize(S_AXI_arsize),
        .S_AXI_arburst(S_AXI_arburst), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rlast(S_AXI_rlast),
        .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic        wlst [16];

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic flag_failure(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    function automatic logic ready_of(input int ch);
        case (ch)
            0:       return S_AXI_awready;
            1:       return S_AXI_wready;
            2:       return S_AXI_bvalid;
            3:       return S_AXI_arready;
            default: return S_AXI_rvalid;
        endcase
    endfunction

    // Waits (bounded) for the channel's ready/valid, then lets one edge complete the handshake.
    task automatic handshake(input int ch, input string name);
        int t = 0;
        while (!ready_of(ch) && t < 200) begin
            @(posedge ACLK); #1;
            t++;
        end
        if (t >= 200) flag_failure({name, "_timeout"});
        @(posedge ACLK); #1;
    endtask

    task automatic set_beat(input int i, input logic [31:0] d, input logic [3:0] s, input logic l);
        wdat[i] = d;
        wstb[i] = s;
        wlst[i] = l;
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
        rbeat_t e;
        e.data = d;
        e.resp = r;
        e.last = l;
        exp_r.push_back(e);
    endtask

    task automatic apply_stimulus_write(input logic [31:0] addr, input logic [7:0] len,
                                        input logic [1:0] burst, input logic [1:0] resp);
        exp_b.push_back(resp);
        S_AXI_awaddr  = addr;
        S_AXI_awlen   = len;
        S_AXI_awburst = burst;
        S_AXI_awvalid = 1'b1;
        handshake(0, "aw");
        S_AXI_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_wdata  = wdat[i];
            S_AXI_wstrb  = wstb[i];
            S_AXI_wlast  = wlst[i];
            S_AXI_wvalid = 1'b1;
            handshake(1, "w");
        end
        S_AXI_wvalid = 1'b0;
        S_AXI_wlast  = 1'b0;
        S_AXI_bready = 1'b1;
        handshake(2, "b");
        S_AXI_bready = 1'b0;
    endtask

    task automatic write_single(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        set_beat(0, d, s, 1'b1);
        apply_stimulus_write(addr, 8'd0, INCR, 2'b00);
    endtask

    // Expected beats must be pushed by the caller; stall_beat < 0 means no backpressure.
    task automatic apply_stimulus_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                                       input int stall_beat, input logic [31:0] stall_data);
        int beats = 0;
        int t = 0;
        S_AXI_rready  = 1'b1;
        S_AXI_araddr  = addr;
        S_AXI_arlen   = len;
        S_AXI_arburst = burst;
        S_AXI_arvalid = 1'b1;
        handshake(3, "ar");
        S_AXI_arvalid = 1'b0;
        while (beats <= int'(len) && t < 200) begin
            if (S_AXI_rvalid) begin
                if (beats == stall_beat) begin
                    S_AXI_rready = 1'b0;
                    repeat (3) begin
                        @(posedge ACLK); #1;
                        check_output("stall_rvalid", {31'd0, S_AXI_rvalid}, 32'd1);
                        check_output("stall_rdata", S_AXI_rdata, stall_data);
                    end
                    S_AXI_rready = 1'b1;
                end
                beats++;
            end
            @(posedge ACLK); #1;
            t++;
        end
        if (t >= 200) flag_failure("r_timeout");
        check_output("rvalid_after_last", {31'd0, S_AXI_rvalid}, 32'd0);
        S_AXI_rready = 1'b0;
    endtask

    initial begin : monitor
        rbeat_t     e;
        logic [1:0] eb;
        forever begin
            @(negedge ACLK);
            if (ARESETN && S_AXI_bvalid && S_AXI_bready) begin
                if (exp_b.size() == 0) flag_failure("b_unexpected");
                else begin
                    eb = exp_b.pop_front();
                    check_output("bresp", {30'd0, S_AXI_bresp}, {30'd0, eb});
                end
            end
            if (ARESETN && S_AXI_rvalid && S_AXI_rready) begin
                if (exp_r.size() == 0) flag_failure("r_unexpected");
                else begin
                    e = exp_r.pop_front();
                    check_output("rdata", S_AXI_rdata, e.data);
                    check_output("rresp_rlast", {29'd0, S_AXI_rresp, S_AXI_rlast}, {29'd0, e.resp, e.last});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        repeat (2) @(posedge ACLK);
        #1;
        check_output("rst_awready", {31'd0, S_AXI_awready}, 32'd1);
        check_output("rst_arready", {31'd0, S_AXI_arready}, 32'd1);
        check_output("rst_wready", {31'd0, S_AXI_wready}, 32'd0);
        check_output("rst_bvalid", {31'd0, S_AXI_bvalid}, 32'd0);
        check_output("rst_bresp", {30'd0, S_AXI_bresp}, 32'd0);
        check_output("rst_rvalid", {31'd0, S_AXI_rvalid}, 32'd0);
        check_output("rst_rlast", {31'd0, S_AXI_rlast}, 32'd0);
        check_output("rst_rdata", S_AXI_rdata, 32'd0);
        check_output("rst_rresp", {30'd0, S_AXI_rresp}, 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        write_single(32'h10, 32'hDEAD_BEEF, 4'hF);
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1);
        apply_stimulus_read(32'h10, 8'd0, INCR, -1, 32'd0);

        for (int i = 0; i < 4; i++) set_beat(i, 32'(i + 1), 4'hF, i == 3);
        apply_stimulus_write(32'h20, 8'd3, INCR, 2'b00);
        for (int i = 0; i < 4; i++) push_r(32'(i + 1), 2'b00, i == 3);
        apply_stimulus_read(32'h20, 8'd3, INCR, -1, 32'd0);
        for (int i = 0; i < 4; i++) push_r(32'd1, 2'b00, i == 3);
        apply_stimulus_read(32'h20, 8'd3, FIXED, -1, 32'd0);

        write_single(32'h40, 32'h1122_3344, 4'hF);
        write_single(32'h40, 32'hAABB_CCDD, 4'b0101);
        push_r(32'h11BB_33DD, 2'b00, 1'b1);
        apply_stimulus_read(32'h40, 8'd0, INCR, -1, 32'd0);

        for (int i = 0; i < 4; i++) push_r(32'(i + 1), 2'b00, i == 3);
        apply_stimulus_read(32'h20, 8'd3, INCR, 1, 32'd2);

        // FIXED write burst: only the last beat survives at the single address
        for (int i = 0; i < 3; i++) set_beat(i, 32'(i + 7), 4'hF, i == 2);
        apply_stimulus_write(32'h90, 8'd2, FIXED, 2'b00);
        push_r(32'd9, 2'b00, 1'b0);
        push_r(32'h0, 2'b00, 1'b1);
        write_single(32'h94, 32'h0, 4'hF);
        apply_stimulus_read(32'h90, 8'd1, INCR, -1, 32'd0);

        set_beat(0, 32'h6060_0000, 4'hF, 1'b1);
        set_beat(1, 32'h6060_0001, 4'hF, 1'b1);
        apply_stimulus_write(32'h60, 8'd1, INCR, 2'b10);

        write_single(32'h0, 32'hCAFE_0000, 4'hF);
`ifdef AXI_MEM_RANGE_CHECK_EN
        push_r(32'h0, 2'b10, 1'b1);
`else
        push_r(32'hCAFE_0000, 2'b00, 1'b1);
`endif
        apply_stimulus_read(32'h400, 8'd0, INCR, -1, 32'd0);

        // Reset in the middle of a 4-beat write: first two beats must persist, third word untouched
        write_single(32'h88, 32'h5555_0088, 4'hF);
        S_AXI_awaddr  = 32'h80;
        S_AXI_awlen   = 8'd3;
        S_AXI_awburst = INCR;
        S_AXI_awvalid = 1'b1;
        handshake(0, "aw_rst");
        S_AXI_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            S_AXI_wdata  = 32'hA0 + 32'(i);
            S_AXI_wstrb  = 4'hF;
            S_AXI_wlast  = 1'b0;
            S_AXI_wvalid = 1'b1;
            handshake(1, "w_rst");
        end
        S_AXI_wvalid = 1'b0;
        check_output("mid_wready", {31'd0, S_AXI_wready}, 32'd1);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        check_output("mid_rst_awready", {31'd0, S_AXI_awready}, 32'd1);
        check_output("mid_rst_wready", {31'd0, S_AXI_wready}, 32'd0);
        check_output("mid_rst_bvalid", {31'd0, S_AXI_bvalid}, 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        push_r(32'hA0, 2'b00, 1'b0);
        push_r(32'hA1, 2'b00, 1'b0);
        push_r(32'h5555_0088, 2'b00, 1'b1);
        apply_stimulus_read(32'h80, 8'd2, INCR, -1, 32'd0);

        repeat (5) @(posedge ACLK);
        #1;
        check_output("b_queue_left", exp_b.size(), 32'd0);
        check_output("r_queue_left", exp_r.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
